difftest_commit_sched: RTL and testbench

//  Sequences retired-instruction and exception events from the dual-commit pipeline

---
 rtl/difftest_pkg.sv | 22 ++
 rtl/difftest_commit_sched_if.sv | 54 +++++
 rtl/difftest_fifo.sv | 56 +++++
 rtl/difftest_commit_sched.sv | 110 +++++++++++
 tb/tb_difftest_commit_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/difftest_pkg.sv
// Shared types for the difftest commit scheduler.
// Commit record, scheduler states and index width.
package difftest_pkg;

    localparam int DIFF_IDXW = 8;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        EMIT
    } sched_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic        skip;
    } commit_entry_t;

endpackage

// File: rtl/difftest_commit_sched_if.sv
// Pipeline-side commit/exception inputs and bridge-side outputs.
// slave is the scheduler's view; master is the driver/observer's view.
interface difftest_commit_sched_if
    import difftest_pkg::*;
#(
    parameter int IDXW = DIFF_IDXW
) ();

    logic [1:0]       c_valid;
    logic [1:0][63:0] c_pc;
    logic [1:0][31:0] c_instr;
    logic [1:0]       c_wen;
    logic [1:0][7:0]  c_wdest;
    logic [1:0][63:0] c_wdata;
    logic [1:0]       c_skip;
    logic             c_ready;

    logic             excp_valid;
    logic [31:0]      excp_cause;
    logic [63:0]      excp_pc;
    logic             excp_ready;

    logic             o_valid;
    logic [IDXW-1:0]  o_index;
    logic [63:0]      o_pc;
    logic [31:0]      o_instr;
    logic             o_wen;
    logic [7:0]       o_wdest;
    logic [63:0]      o_wdata;
    logic             o_skip;
    logic             o_excp_valid;
    logic [31:0]      o_excp_cause;
    logic [63:0]      o_excp_pc;
    logic             overflow_err;

    modport slave (
        input  c_valid, c_pc, c_instr, c_wen, c_wdest, c_wdata, c_skip,
        input  excp_valid, excp_cause, excp_pc,
        output c_ready, excp_ready,
        output o_valid, o_index, o_pc, o_instr, o_wen, o_wdest,
        output o_wdata, o_skip, o_excp_valid, o_excp_cause, o_excp_pc,
        output overflow_err
    );

    modport master (
        output c_valid, c_pc, c_instr, c_wen, c_wdest, c_wdata, c_skip,
        output excp_valid, excp_cause, excp_pc,
        input  c_ready, excp_ready,
        input  o_valid, o_index, o_pc, o_instr, o_wen, o_wdest,
        input  o_wdata, o_skip, o_excp_valid, o_excp_cause, o_excp_pc,
        input  overflow_err
    );

endinterface

// File: rtl/difftest_fifo.sv
// Two-write / one-read FIFO of commit records with occupancy count.
// Read data is the current head; callers never pop an empty FIFO.
module difftest_fifo
    import difftest_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_we,
    input  commit_entry_t [1:0]   i_wdata,
    input  logic                  i_re,
    output commit_entry_t         o_rdata,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    commit_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;

    logic          w_we0;
    logic          w_we1;
    commit_entry_t w_d0;
    logic [CW-1:0] w_nw;

    // a lone lane1 write takes the first free slot
    assign w_we0 = |i_we;
    assign w_we1 = &i_we;
    assign w_d0  = i_we[0] ? i_wdata[0] : i_wdata[1];
    assign w_nw  = CW'(i_we[0]) + CW'(i_we[1]);

    always_ff @(posedge clk) begin
        if (w_we0) r_mem[r_wp] <= w_d0;
        if (w_we1) r_mem[r_wp + AW'(1)] <= i_wdata[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_wp    <= r_wp + AW'(w_nw);
            if (i_re) r_rp <= r_rp + AW'(1);
            r_count <= r_count + w_nw - CW'(i_re);
        end
    end

    assign o_rdata = r_mem[r_rp];
    assign o_count = r_count;

endmodule

// File: rtl/difftest_commit_sched.sv
// Orders dual-lane commits and exceptions into the single-lane difftest bridge.
// Exceptions wait until every older commit has been emitted.
module difftest_commit_sched
    import difftest_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDXW  = DIFF_IDXW
) (
    input  logic clock,
    input  logic reset_n,
    difftest_commit_sched_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    sched_state_e        r_state;
    logic [IDXW-1:0]     r_idx;

    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_free;
    logic                w_pop;
    logic                w_ready;
    logic [1:0]          w_push;
    commit_entry_t [1:0] w_din;
    commit_entry_t       w_head;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        assign w_din[g] = '{
            pc:    bus.c_pc[g],
            instr: bus.c_instr[g],
            wen:   bus.c_wen[g],
            wdest: bus.c_wdest[g],
            wdata: bus.c_wdata[g],
            skip:  bus.c_skip[g]
        };
    end

    // free space credits the entry leaving this cycle
    assign w_pop   = (w_count != '0);
    assign w_free  = CW'(DEPTH) - w_count + CW'(w_pop);
    assign w_ready = (r_state == RUN) && (w_free >= CW'(2));
    assign w_push  = w_ready ? bus.c_valid : 2'b00;

    assign bus.c_ready    = w_ready;
    assign bus.excp_ready = (r_state == RUN);

    difftest_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clock),
        .rst_n  (reset_n),
        .i_we   (w_push),
        .i_wdata(w_din),
        .i_re   (w_pop),
        .o_rdata(w_head),
        .o_count(w_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= RUN;
            r_idx            <= '0;
            bus.o_valid      <= 1'b0;
            bus.o_index      <= '0;
            bus.o_pc         <= '0;
            bus.o_instr      <= '0;
            bus.o_wen        <= 1'b0;
            bus.o_wdest      <= '0;
            bus.o_wdata      <= '0;
            bus.o_skip       <= 1'b0;
            bus.o_excp_valid <= 1'b0;
            bus.o_excp_cause <= '0;
            bus.o_excp_pc    <= '0;
            bus.overflow_err <= 1'b0;
        end else begin
            bus.o_valid <= w_pop;
            if (w_pop) begin
                bus.o_index <= r_idx;
                bus.o_pc    <= w_head.pc;
                bus.o_instr <= w_head.instr;
                bus.o_wen   <= w_head.wen;
                bus.o_wdest <= w_head.wdest;
                bus.o_wdata <= w_head.wdata;
                bus.o_skip  <= w_head.skip;
                r_idx       <= r_idx + IDXW'(1);
            end
            if ((|bus.c_valid) && !w_ready) bus.overflow_err <= 1'b1;
            bus.o_excp_valid <= 1'b0;
            unique case (r_state)
                RUN: begin
                    if (bus.excp_valid) begin
                        bus.o_excp_cause <= bus.excp_cause;
                        bus.o_excp_pc    <= bus.excp_pc;
                        r_state          <= DRAIN;
                    end
                end
                DRAIN: begin
                    // empty count means the last pop already left
                    if (w_count == '0) begin
                        bus.o_excp_valid <= 1'b1;
                        r_state          <= EMIT;
                    end
                end
                EMIT:    r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_difftest_commit_sched.sv
// Self-checking bench for difftest_commit_sched.
// Vector table, directed corner sequences and random traffic vs a queue model.
module tb_difftest_commit_sched;
    import difftest_pkg::*;

    localparam int DEPTH = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    difftest_commit_sched_if #(.IDXW(DIFF_IDXW)) bus ();

    difftest_commit_sched #(
        .DEPTH(DEPTH),
        .IDXW (DIFF_IDXW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model: FIFO contents as a queue, exception phase as a counter
    commit_entry_t q[$];
    int            m_idx;
    int            xs;
    logic          m_ovf;
    logic [31:0]   l_cause;
    logic [63:0]   l_pc;

    logic          obs_rdy;
    logic          obs_ov;
    logic          obs_xv;
    logic          seen_dead;
    logic [7:0]    seen_idx[$];

    typedef struct {
        logic [1:0]  cv;
        logic [63:0] pc0;
        logic [63:0] pc1;
        logic        xv;
        logic [31:0] xc;
        logic        e_rdy;
        logic        e_ov;
        logic [63:0] e_pc;
        logic [7:0]  e_idx;
        logic        e_xv;
        logic [31:0] e_xc;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic commit_entry_t mk(input logic [63:0] pc);
        commit_entry_t e;
        e.pc    = pc;
        e.instr = pc[31:0] ^ 32'h0000_0013;
        e.wen   = pc[2];
        e.wdest = pc[9:2];
        e.wdata = ~pc;
        e.skip  = pc[3];
        return e;
    endfunction

    function automatic commit_entry_t lane(input int i);
        commit_entry_t e;
        e.pc    = bus.c_pc[i];
        e.instr = bus.c_instr[i];
        e.wen   = bus.c_wen[i];
        e.wdest = bus.c_wdest[i];
        e.wdata = bus.c_wdata[i];
        e.skip  = bus.c_skip[i];
        return e;
    endfunction

    task automatic drive(input logic [1:0] cv, input logic [63:0] pc0,
                         input logic [63:0] pc1, input logic xv,
                         input logic [31:0] xc, input logic [63:0] xp);
        commit_entry_t e[2];
        e[0] = mk(pc0);
        e[1] = mk(pc1);
        bus.c_valid = cv;
        for (int i = 0; i < 2; i++) begin
            bus.c_pc[i]    = e[i].pc;
            bus.c_instr[i] = e[i].instr;
            bus.c_wen[i]   = e[i].wen;
            bus.c_wdest[i] = e[i].wdest;
            bus.c_wdata[i] = e[i].wdata;
            bus.c_skip[i]  = e[i].skip;
        end
        bus.excp_valid = xv;
        bus.excp_cause = xc;
        bus.excp_pc    = xp;
    endtask

    task automatic idle();
        drive(2'b00, 64'h0, 64'h0, 1'b0, 32'h0, 64'h0);
    endtask

    // one clock: check handshakes before the edge, outputs after it
    task automatic cycle();
        int            sz;
        logic          pop;
        logic          rdy;
        logic          pulse;
        commit_entry_t cur;
        #1;
        sz  = q.size();
        pop = (sz > 0);
        rdy = (xs == 0) && (DEPTH - sz + int'(pop) >= 2);
        obs_rdy = bus.c_ready;
        chk("c_ready", 64'(bus.c_ready), 64'(rdy));
        chk("excp_ready", 64'(bus.excp_ready), 64'(xs == 0));
        @(posedge clock);
        cur = '0;
        if (pop) cur = q.pop_front();
        if (rdy) begin
            for (int i = 0; i < 2; i++)
                if (bus.c_valid[i]) q.push_back(lane(i));
        end else if (bus.c_valid != 2'b00) begin
            m_ovf = 1'b1;
        end
        pulse = 1'b0;
        if (xs == 0) begin
            if (bus.excp_valid) begin
                xs      = 1;
                l_cause = bus.excp_cause;
                l_pc    = bus.excp_pc;
            end
        end else if (xs == 1) begin
            if (sz == 0) begin
                xs    = 2;
                pulse = 1'b1;
            end
        end else begin
            xs = 0;
        end
        #1;
        obs_ov = bus.o_valid;
        obs_xv = bus.o_excp_valid;
        if (bus.o_valid && bus.o_pc == 64'hdead_0000) seen_dead = 1'b1;
        chk("o_valid", 64'(bus.o_valid), 64'(pop));
        if (pop) begin
            chk("o_index", 64'(bus.o_index), 64'(m_idx[7:0]));
            chk("o_pc", bus.o_pc, cur.pc);
            chk("o_instr", 64'(bus.o_instr), 64'(cur.instr));
            chk("o_wen", 64'(bus.o_wen), 64'(cur.wen));
            chk("o_wdest", 64'(bus.o_wdest), 64'(cur.wdest));
            chk("o_wdata", bus.o_wdata, cur.wdata);
            chk("o_skip", 64'(bus.o_skip), 64'(cur.skip));
            seen_idx.push_back(bus.o_index);
            m_idx = (m_idx + 1) % 256;
        end
        chk("o_excp_valid", 64'(bus.o_excp_valid), 64'(pulse));
        if (pulse) begin
            chk("o_excp_cause", 64'(bus.o_excp_cause), 64'(l_cause));
            chk("o_excp_pc", bus.o_excp_pc, l_pc);
        end
        chk("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
        chk("fifo_count", 64'(dut.w_count), 64'(q.size()));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " o_valid"}, 64'(bus.o_valid), 64'(0));
        chk({tag, " o_index"}, 64'(bus.o_index), 64'(0));
        chk({tag, " o_pc"}, bus.o_pc, 64'(0));
        chk({tag, " o_instr"}, 64'(bus.o_instr), 64'(0));
        chk({tag, " o_wen"}, 64'(bus.o_wen), 64'(0));
        chk({tag, " o_wdest"}, 64'(bus.o_wdest), 64'(0));
        chk({tag, " o_wdata"}, bus.o_wdata, 64'(0));
        chk({tag, " o_skip"}, 64'(bus.o_skip), 64'(0));
        chk({tag, " o_excp_valid"}, 64'(bus.o_excp_valid), 64'(0));
        chk({tag, " o_excp_cause"}, 64'(bus.o_excp_cause), 64'(0));
        chk({tag, " o_excp_pc"}, bus.o_excp_pc, 64'(0));
        chk({tag, " overflow_err"}, 64'(bus.overflow_err), 64'(0));
        chk({tag, " c_ready"}, 64'(bus.c_ready), 64'(1));
        chk({tag, " excp_ready"}, 64'(bus.excp_ready), 64'(1));
    endtask

    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 chk_zero(tag);
        idle();
        q.delete();
        seen_idx.delete();
        m_idx = 0;
        xs    = 0;
        m_ovf = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        int lastv;
        int pk;
        int rdy_seen;
        int np;
        int stalls;
        int maxq;
        logic [31:0] cause;

        tv[0] = '{2'b11, 64'h8000_0000, 64'h8000_0004, 1'b0, 32'h0,
                  1'b1, 1'b0, 64'h0, 8'd0, 1'b0, 32'h0};
        tv[1] = '{2'b00, 64'h0, 64'h0, 1'b0, 32'h0,
                  1'b1, 1'b1, 64'h8000_0000, 8'd0, 1'b0, 32'h0};
        tv[2] = '{2'b00, 64'h0, 64'h0, 1'b0, 32'h0,
                  1'b1, 1'b1, 64'h8000_0004, 8'd1, 1'b0, 32'h0};
        tv[3] = '{2'b01, 64'h8000_0008, 64'h0, 1'b1, 32'h5,
                  1'b1, 1'b0, 64'h0, 8'd0, 1'b0, 32'h0};
        tv[4] = '{2'b00, 64'h0, 64'h0, 1'b0, 32'h0,
                  1'b0, 1'b1, 64'h8000_0008, 8'd2, 1'b0, 32'h0};
        tv[5] = '{2'b00, 64'h0, 64'h0, 1'b0, 32'h0,
                  1'b0, 1'b0, 64'h0, 8'd0, 1'b1, 32'h5};
        tv[6] = '{2'b00, 64'h0, 64'h0, 1'b0, 32'h0,
                  1'b0, 1'b0, 64'h0, 8'd0, 1'b0, 32'h0};
        tv[7] = '{2'b00, 64'h0, 64'h0, 1'b0, 32'h0,
                  1'b1, 1'b0, 64'h0, 8'd0, 1'b0, 32'h0};

        seen_dead = 1'b0;
        idle();
        do_reset("reset");

        // in-order pair, then exception alongside an older commit
        for (int r = 0; r < 8; r++) begin
            drive(tv[r].cv, tv[r].pc0, tv[r].pc1, tv[r].xv, tv[r].xc,
                  64'h8000_0200);
            cycle();
            chk($sformatf("tv%0d c_ready", r), 64'(obs_rdy), 64'(tv[r].e_rdy));
            chk($sformatf("tv%0d o_valid", r), 64'(obs_ov), 64'(tv[r].e_ov));
            if (tv[r].e_ov) begin
                chk($sformatf("tv%0d o_pc", r), bus.o_pc, tv[r].e_pc);
                chk($sformatf("tv%0d o_index", r), 64'(bus.o_index),
                    64'(tv[r].e_idx));
            end
            chk($sformatf("tv%0d o_excp_valid", r), 64'(obs_xv),
                64'(tv[r].e_xv));
            if (tv[r].e_xv)
                chk($sformatf("tv%0d o_excp_cause", r),
                    64'(bus.o_excp_cause), 64'(tv[r].e_xc));
        end

        // back-to-back dual commits fill the FIFO
        do_reset("t2 reset");
        stalls = 0;
        maxq   = 0;
        for (int k = 0; k < 24; k++) begin
            if (bus.c_ready)
                drive(2'b11, 64'(32'h1000 + k * 16), 64'(32'h1008 + k * 16),
                      1'b0, 32'h0, 64'h0);
            else begin
                idle();
                stalls++;
            end
            cycle();
            if (q.size() > maxq) maxq = q.size();
        end
        chk("t2 c_ready stalled", 64'(stalls > 0), 64'(1));
        chk("t2 peak count", 64'(maxq), 64'(DEPTH));
        chk("t2 overflow_err", 64'(bus.overflow_err), 64'(0));
        idle();
        repeat (10) cycle();

        // index wrap
        do_reset("t3 reset");
        for (int k = 0; k < 258; k++) begin
            drive(2'b01, 64'(32'h4000_0000 + k * 4), 64'h0, 1'b0, 32'h0,
                  64'h0);
            cycle();
        end
        idle();
        repeat (3) cycle();
        chk("t3 commits", 64'(seen_idx.size()), 64'(258));
        chk("t3 idx254", 64'(seen_idx[254]), 64'(254));
        chk("t3 idx255", 64'(seen_idx[255]), 64'(255));
        chk("t3 idx256", 64'(seen_idx[256]), 64'(0));
        chk("t3 idx257", 64'(seen_idx[257]), 64'(1));

        // exception waits for three queued commits
        do_reset("t4 reset");
        drive(2'b11, 64'h8000_0010, 64'h8000_0014, 1'b0, 32'h0, 64'h0);
        cycle();
        drive(2'b11, 64'h8000_0018, 64'h8000_001c, 1'b0, 32'h0, 64'h0);
        cycle();
        drive(2'b00, 64'h0, 64'h0, 1'b1, 32'hB, 64'h8000_0100);
        cycle();
        idle();
        nv       = int'(obs_ov);
        lastv    = 0;
        pk       = -1;
        rdy_seen = 0;
        cause    = 32'h0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (obs_rdy) rdy_seen++;
            if (obs_ov) begin
                nv++;
                lastv = k;
            end
            if (obs_xv) begin
                pk    = k;
                cause = bus.o_excp_cause;
                break;
            end
        end
        chk("t4 drained commits", 64'(nv), 64'(3));
        chk("t4 pulse seen", 64'(pk > 0), 64'(1));
        chk("t4 pulse gap", 64'(pk), 64'(lastv + 1));
        chk("t4 cause", 64'(cause), 64'(32'hB));
        chk("t4 c_ready during drain", 64'(rdy_seen), 64'(0));
        np = 0;
        repeat (5) begin
            cycle();
            if (obs_xv) np++;
        end
        chk("t4 extra pulses", 64'(np), 64'(0));

        // drop while draining, then reset mid-drain
        do_reset("t6 reset");
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 64'(32'h2000 + k * 16), 64'(32'h2008 + k * 16),
                  1'b0, 32'h0, 64'h0);
            cycle();
        end
        drive(2'b00, 64'h0, 64'h0, 1'b1, 32'h2, 64'h2200);
        cycle();
        drive(2'b01, 64'hdead_0000, 64'h0, 1'b0, 32'h0, 64'h0);
        cycle();
        chk("t6 overflow set", 64'(bus.overflow_err), 64'(1));
        idle();
        cycle();
        chk("t6 overflow sticky", 64'(bus.overflow_err), 64'(1));
        chk("t6 still draining", 64'(bus.o_valid), 64'(1));
        do_reset("t6 mid-drain");
        np = 0;
        repeat (6) begin
            cycle();
            if (obs_xv) np++;
        end
        chk("t6 no pulse after reset", 64'(np), 64'(0));
        chk("t6 dropped commit", 64'(seen_dead), 64'(0));

        // random traffic
        do_reset("rand reset");
        for (int k = 0; k < 400; k++) begin
            logic [1:0] cv;
            logic       xv;
            if (bus.c_ready)
                cv = 2'($urandom_range(0, 3));
            else if ($urandom_range(0, 24) == 0)
                cv = 2'($urandom_range(1, 3));
            else
                cv = 2'b00;
            xv = ($urandom_range(0, 11) == 0);
            drive(cv, {$urandom, $urandom}, {$urandom, $urandom}, xv,
                  $urandom, {$urandom, $urandom});
            cycle();
        end
        idle();
        repeat (20) cycle();
        chk("rand drained", 64'(dut.w_count), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
